// File: rtl/pic_pkg.sv
// Shared types and helpers for the interrupt acknowledge sequencer.
// Level 0 is the highest priority; level 7 doubles as the spurious vector.
package pic_pkg;

    localparam int NUM_IR  = 8;
    localparam int LEVEL_W = 3;
    localparam int BASE_W  = 8 - LEVEL_W;

    localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = LEVEL_W'(7);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        ACK1,
        ACK2
    } state_t;

    typedef struct packed {
        logic               found;
        logic [LEVEL_W-1:0] idx;
    } prio_t;

    function automatic prio_t prio_first(input logic [NUM_IR-1:0] vec);
        prio_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = LEVEL_W'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_IR-1:0] level_onehot(
        input logic [LEVEL_W-1:0] lvl
    );
        return NUM_IR'(1) << lvl;
    endfunction

endpackage

// File: rtl/priority_resolver.sv
// Fully-nested priority: the best eligible level wins only if it
// outranks every level currently in service.
module priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0]  eligible_i,
    input  logic [NUM_IR-1:0]  isr_i,
    output logic               request_valid_o,
    output logic [LEVEL_W-1:0] win_o
);

    prio_t req;
    prio_t srv;

    assign req = prio_first(eligible_i);
    assign srv = prio_first(isr_i);

    assign win_o           = req.idx;
    assign request_valid_o = req.found && (!srv.found || (req.idx < srv.idx));

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// INT generation, two-pulse INTA handshake, ISR ownership and EOI
// handling for an 8-level fully-nested interrupt controller.
module interrupt_ack_sequencer
    import pic_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IR-1:0]  interrupt_req_register,
    input  logic [NUM_IR-1:0]  interrupt_mask,
    input  logic [BASE_W-1:0]  vector_base,
    input  logic               auto_eoi,
    input  logic               inta_n,
    input  logic               eoi_req,
    input  logic               eoi_specific,
    input  logic [LEVEL_W-1:0] eoi_level,
    output logic               int_out,
    output logic [NUM_IR-1:0]  clear_interrupt_req,
    output logic [NUM_IR-1:0]  in_service_register,
    output logic [7:0]         data_out,
    output logic               data_out_en
);

    state_t               state_q;
    logic                 inta_q;
    logic [LEVEL_W-1:0]   level_q;
    logic                 spurious_q;
    logic                 int_q;
    logic [NUM_IR-1:0]    clr_q;
    logic [7:0]           dout_q;
    logic                 den_q;
    logic [NUM_IR-1:0]    isr_q;
    logic [NUM_IR-1:0]    isr_d;

    logic [NUM_IR-1:0]    eligible;
    logic [NUM_IR-1:0]    set_mask;
    logic [NUM_IR-1:0]    clr_mask;
    logic                 req_valid;
    logic [LEVEL_W-1:0]   win;
    logic                 fall;
    logic                 rise;
    prio_t                isr_top;

    assign eligible = interrupt_req_register & ~interrupt_mask;
    assign fall     = inta_q & ~inta_n;
    assign rise     = ~inta_q & inta_n;
    assign isr_top  = prio_first(isr_q);

    priority_resolver u_resolver (
        .eligible_i      (eligible),
        .isr_i           (isr_q),
        .request_valid_o (req_valid),
        .win_o           (win)
    );

    // Set is OR-ed in last so it wins over a same-bit clear.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if ((state_q == PEND) && fall && req_valid) begin
            set_mask = level_onehot(win);
        end
        if ((state_q == ACK2) && rise && auto_eoi && !spurious_q) begin
            clr_mask = level_onehot(level_q);
        end
        if (eoi_req) begin
            if (eoi_specific) begin
                clr_mask = clr_mask | level_onehot(eoi_level);
            end else if (isr_top.found) begin
                clr_mask = clr_mask | level_onehot(isr_top.idx);
            end
        end
        isr_d = (isr_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            inta_q     <= 1'b1;
            level_q    <= '0;
            spurious_q <= 1'b0;
            int_q      <= 1'b0;
            clr_q      <= '0;
            dout_q     <= '0;
            den_q      <= 1'b0;
            isr_q      <= '0;
        end else begin
            inta_q <= inta_n;
            isr_q  <= isr_d;
            clr_q  <= '0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        int_q   <= 1'b1;
                        state_q <= PEND;
                    end
                end
                PEND: begin
                    if (fall) begin
                        int_q   <= 1'b0;
                        state_q <= ACK1;
                        if (req_valid) begin
                            level_q    <= win;
                            spurious_q <= 1'b0;
                            clr_q      <= level_onehot(win);
                        end else begin
                            level_q    <= SPURIOUS_LEVEL;
                            spurious_q <= 1'b1;
                        end
                    end else if (!req_valid) begin
                        int_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ACK1: begin
                    if (fall) begin
                        den_q   <= 1'b1;
                        dout_q  <= {vector_base, level_q};
                        state_q <= ACK2;
                    end
                end
                ACK2: begin
                    if (rise) begin
                        den_q   <= 1'b0;
                        dout_q  <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign int_out             = int_q;
    assign clear_interrupt_req = clr_q;
    assign in_service_register = isr_q;
    assign data_out            = dout_q;
    assign data_out_en         = den_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Scoreboard bench for interrupt_ack_sequencer: directed scenarios
// followed by randomized request/mask/EOI traffic.
module tb_interrupt_ack_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irr;
    logic [7:0] imr;
    logic [4:0] base;
    logic       auto_eoi;
    logic       inta_n;
    logic       eoi_req;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] clr;
    logic [7:0] isr;
    logic [7:0] dout;
    logic       den;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] exp_clr[$];
    logic [7:0] exp_vec[$];
    logic [7:0] m_isr;
    logic [2:0] m_lvl;
    bit         m_spur;
    logic       den_prev = 1'b0;

    always #5 clk = ~clk;

    interrupt_ack_sequencer dut (
        .clk                    (clk),
        .reset                  (reset),
        .interrupt_req_register (irr),
        .interrupt_mask         (imr),
        .vector_base            (base),
        .auto_eoi               (auto_eoi),
        .inta_n                 (inta_n),
        .eoi_req                (eoi_req),
        .eoi_specific           (eoi_specific),
        .eoi_level              (eoi_level),
        .int_out                (int_out),
        .clear_interrupt_req    (clr),
        .in_service_register    (isr),
        .data_out               (dout),
        .data_out_en            (den)
    );

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: lowest eligible index must beat lowest in-service index.
    function automatic void pick(input logic [7:0] r, input logic [7:0] m,
                                 input logic [7:0] s, output bit v,
                                 output logic [2:0] w);
        int e = 8;
        int t = 8;
        for (int i = 7; i >= 0; i--) begin
            if (r[i] && !m[i]) e = i;
            if (s[i]) t = i;
        end
        v = (e < t);
        w = v ? 3'(e) : 3'd7;
    endfunction

    function automatic logic [7:0] eoi_mask(input bit spec,
                                            input logic [2:0] lvl,
                                            input logic [7:0] s);
        return spec ? (8'd1 << lvl) : (s & (~s + 8'd1));
    endfunction

    // Monitor: pops expectations whenever the DUT presents a pulse/vector.
    always @(negedge clk) begin
        if (!reset) begin
            if (clr != 8'h00) begin
                if (exp_clr.size() == 0) chk("clr_unexpected", clr, 8'h00);
                else chk("clr_pulse", clr, exp_clr.pop_front());
            end
            if (den && !den_prev) begin
                if (exp_vec.size() == 0) chk("vec_unexpected", dout, 8'hxx);
                else chk("vector", dout, exp_vec.pop_front());
            end
        end
        den_prev = den;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_int();
        bit seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = int_out;
        end
        chk("int_raise", 8'(int_out), 8'h01);
    endtask

    task automatic first_fall(input bit eoi_en, input bit spec,
                              input logic [2:0] lvl, input bit drop);
        bit         v;
        logic [2:0] w;
        logic [7:0] cm;
        cyc(1);
        if (drop) irr = 8'h00;
        inta_n = 1'b0;
        eoi_req = eoi_en;
        eoi_specific = spec;
        eoi_level = lvl;
        pick(irr, imr, m_isr, v, w);
        cm = eoi_en ? eoi_mask(spec, lvl, m_isr) : 8'h00;
        m_spur = !v;
        m_lvl = w;
        if (v) exp_clr.push_back(8'd1 << w);
        exp_vec.push_back({base, m_lvl});
        m_isr = (m_isr & ~cm) | (v ? (8'd1 << w) : 8'h00);
        cyc(1);
        eoi_req = 1'b0;
        if (v) irr[w] = 1'b0;
        cyc(1);
        inta_n = 1'b1;
        cyc(1);
    endtask

    task automatic second_pulse();
        cyc(1);
        inta_n = 1'b0;
        cyc(2);
        inta_n = 1'b1;
        if (auto_eoi && !m_spur) m_isr[m_lvl] = 1'b0;
        cyc(2);
        @(negedge clk);
        chk("den_drop", 8'(den), 8'h00);
        chk("isr_after_ack", isr, m_isr);
    endtask

    task automatic eoi(input bit spec, input logic [2:0] lvl);
        cyc(1);
        eoi_req = 1'b1;
        eoi_specific = spec;
        eoi_level = lvl;
        m_isr = m_isr & ~eoi_mask(spec, lvl, m_isr);
        cyc(1);
        eoi_req = 1'b0;
        @(negedge clk);
        chk("isr_eoi", isr, m_isr);
    endtask

    task automatic serve(input logic [7:0] r);
        irr = r;
        wait_int();
        first_fall(1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        chk("isr_set", isr, m_isr);
        second_pulse();
        irr = 8'h00;
        cyc(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit         v;
        logic [2:0] w;
        reset = 1'b1; irr = 0; imr = 0; base = 5'h08; auto_eoi = 0;
        inta_n = 1'b1; eoi_req = 0; eoi_specific = 0; eoi_level = 0;
        m_isr = 0; m_lvl = 0; m_spur = 0;
        cyc(3);
        @(negedge clk);
        chk("rst_int", 8'(int_out), 8'h00);
        chk("rst_clr", clr, 8'h00);
        chk("rst_isr", isr, 8'h00);
        chk("rst_dout", dout, 8'h00);
        chk("rst_den", 8'(den), 8'h00);
        cyc(1);
        reset = 1'b0;
        cyc(1);

        // single request, exact one-cycle INT latency, vector 0x43
        irr = 8'h08;
        @(negedge clk);
        chk("int_lat0", 8'(int_out), 8'h00);
        @(negedge clk);
        chk("int_lat1", 8'(int_out), 8'h01);
        first_fall(1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        chk("isr_l3", isr, 8'h08);
        second_pulse();
        chk("vec_last", {base, m_lvl}, 8'h43);
        irr = 8'h00;
        eoi(1'b0, 3'd0);

        // priority and nesting
        irr = 8'h21;
        wait_int();
        first_fall(1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        chk("isr_l0", isr, 8'h01);
        second_pulse();
        irr = 8'h20;
        cyc(4);
        @(negedge clk);
        chk("nested_block", 8'(int_out), 8'h00);
        eoi(1'b0, 3'd0);
        chk("isr_clear0", isr, 8'h00);
        wait_int();
        first_fall(1'b0, 1'b0, 3'd0, 1'b0);
        second_pulse();
        irr = 8'h00;
        eoi(1'b0, 3'd0);

        // masking, vanished request, spurious
        imr = 8'hFF; irr = 8'hFF;
        cyc(4);
        @(negedge clk);
        chk("masked", 8'(int_out), 8'h00);
        imr = 8'h00; irr = 8'h10;
        wait_int();
        cyc(1);
        irr = 8'h00;
        cyc(2);
        @(negedge clk);
        chk("int_vanish", 8'(int_out), 8'h00);
        irr = 8'h10;
        wait_int();
        first_fall(1'b0, 1'b0, 3'd0, 1'b1);
        @(negedge clk);
        chk("spur_int", 8'(int_out), 8'h00);
        chk("spur_isr", isr, 8'h00);
        second_pulse();

        // auto EOI
        auto_eoi = 1'b1;
        irr = 8'h04;
        wait_int();
        first_fall(1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        chk("aeoi_set", isr, 8'h04);
        second_pulse();
        chk("aeoi_clr", isr, 8'h00);
        auto_eoi = 1'b0;
        irr = 8'h00;
        cyc(2);

        // specific EOI and same-cycle set/clear
        serve(8'h08);
        serve(8'h02);
        chk("isr_0a", isr, 8'h0A);
        eoi(1'b1, 3'd3);
        chk("isr_spec3", isr, 8'h02);
        eoi(1'b1, 3'd1);
        serve(8'h08);
        irr = 8'h02;
        wait_int();
        first_fall(1'b1, 1'b1, 3'd3, 1'b0);
        @(negedge clk);
        chk("same_cyc_diff", isr, 8'h02);
        second_pulse();
        irr = 8'h00;
        eoi(1'b0, 3'd0);
        irr = 8'h04;
        wait_int();
        first_fall(1'b1, 1'b1, 3'd2, 1'b0);
        @(negedge clk);
        chk("same_cyc_same", isr, 8'h04);
        second_pulse();
        irr = 8'h00;
        eoi(1'b0, 3'd0);
        cyc(2);

        // reset between the two INTA pulses
        irr = 8'h02;
        wait_int();
        first_fall(1'b0, 1'b0, 3'd0, 1'b0);
        reset = 1'b1;
        cyc(2);
        @(negedge clk);
        chk("mid_rst_int", 8'(int_out), 8'h00);
        chk("mid_rst_isr", isr, 8'h00);
        chk("mid_rst_den", 8'(den), 8'h00);
        chk("mid_rst_dout", dout, 8'h00);
        chk("mid_rst_clr", clr, 8'h00);
        exp_vec.delete();
        m_isr = 8'h00;
        irr = 8'h00;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        serve(8'h02);
        chk("post_rst_isr", isr, 8'h02);
        eoi(1'b0, 3'd0);

        // randomized traffic
        for (int it = 0; it < 30; it++) begin
            if (m_isr != 0 && $urandom_range(0, 1) == 1)
                eoi(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            base = 5'($urandom);
            auto_eoi = 1'($urandom_range(0, 1));
            imr = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            irr = 8'($urandom_range(1, 255));
            pick(irr, imr, m_isr, v, w);
            if (v) begin
                wait_int();
                first_fall(1'b0, 1'b0, 3'd0, 1'b0);
                @(negedge clk);
                chk("rnd_isr_set", isr, m_isr);
                second_pulse();
            end else begin
                cyc(3);
                @(negedge clk);
                chk("rnd_no_int", 8'(int_out), 8'h00);
            end
            irr = 8'h00;
            cyc(2);
        end

        cyc(3);
        chk("scb_drain", 8'(exp_clr.size() + exp_vec.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
